// File: rtl/rob.sv
// Reorder buffer: in-order allocation at tail, out-of-order writeback,
// in-order retire at head, and a full flush when the head entry carries an error.
module rob #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rename_valid,
    input  logic [5:0]  rename_rd,
    output logic [7:0]  rename_robid,
    output logic        rob_full,
    input  logic        wb_valid,
    input  logic        wb_error,
    input  logic [7:0]  wb_robid,
    input  logic [5:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic        rob_flush,
    output logic        rob_ret_valid,
    output logic [5:0]  rob_ret_rd,
    output logic [31:0] rob_ret_result
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    logic [DEPTH-1:0] valid_q, done_q, err_q;
    logic [5:0]       rd_q  [DEPTH];
    logic [31:0]      res_q [DEPTH];

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             flush_q, flush_d;
    logic             ret_valid_q, ret_valid_d;
    logic [5:0]       ret_rd_q, ret_rd_d;
    logic [31:0]      ret_res_q, ret_res_d;

    logic [IDX_W-1:0] wb_idx;
    logic             head_ready, do_retire, do_flush, do_alloc, do_wb;

    // wb_rd is informational only and the upper robid bits are beyond DEPTH
    logic unused_wb;
    assign unused_wb = ^{wb_rd, wb_robid[7:IDX_W]};

    assign wb_idx     = wb_robid[IDX_W-1:0];
    assign head_ready = valid_q[head_q] & done_q[head_q];
    assign do_retire  = head_ready & ~err_q[head_q];
    assign do_flush   = head_ready & err_q[head_q];
    // Anything presented on the flush edge or while the flush pulse is high is dropped
    assign do_alloc   = rename_valid & ~rob_full & ~flush_q & ~do_flush;
    assign do_wb      = wb_valid & ~flush_q & ~do_flush & valid_q[wb_idx];

    assign rob_full       = (count_q == FULL_CNT);
    assign rename_robid   = 8'(tail_q);
    assign rob_flush      = flush_q;
    assign rob_ret_valid  = ret_valid_q;
    assign rob_ret_rd     = ret_rd_q;
    assign rob_ret_result = ret_res_q;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        flush_d     = 1'b0;
        ret_valid_d = 1'b0;
        ret_rd_d    = ret_rd_q;
        ret_res_d   = ret_res_q;
        if (do_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            flush_d = 1'b1;
        end else begin
            if (do_retire) begin
                ret_valid_d = 1'b1;
                ret_rd_d    = rd_q[head_q];
                ret_res_d   = res_q[head_q];
                head_d      = head_q + 1'b1;
            end
            if (do_alloc) begin
                tail_d = tail_q + 1'b1;
            end
            case ({do_alloc, do_retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            flush_q     <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_rd_q    <= '0;
            ret_res_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            flush_q     <= flush_d;
            ret_valid_q <= ret_valid_d;
            ret_rd_q    <= ret_rd_d;
            ret_res_q   <= ret_res_d;
            if (do_flush) begin
                valid_q <= '0;
                done_q  <= '0;
                err_q   <= '0;
            end else begin
                if (do_wb) begin
                    done_q[wb_idx] <= 1'b1;
                    err_q[wb_idx]  <= wb_error;
                end
                if (do_retire) begin
                    valid_q[head_q] <= 1'b0;
                end
                if (do_alloc) begin
                    valid_q[tail_q] <= 1'b1;
                    done_q[tail_q]  <= 1'b0;
                    err_q[tail_q]   <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: valid/done gate every use of it
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            rd_q[tail_q] <= rename_rd;
        end
        if (do_wb) begin
            res_q[wb_idx] <= wb_result;
        end
    end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, 2..128.
REQ-002 Parameter IDX_W, default 4, log2(DEPTH).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 rename_valid  in  1  allocate one entry this cycle.
REQ-006 rename_rd  in  6  destination register of the allocating instruction.
REQ-007 rename_robid  out  8  id of the entry allocated this cycle: tail pointer zero-extended to 8 bits, combinational.
REQ-008 rob_full  out  1  no free entry, combinational; upstream must not present rename_valid while high.
REQ-009 wb_valid  in  1  writeback strobe.
REQ-010 wb_error  in  1  writeback carries an exception.
REQ-011 wb_robid  in  8  entry being written back; only bits [IDX_W-1:0] used.
REQ-012 wb_rd  in  6  destination of the writeback; informational, not stored.
REQ-013 wb_result  in  32  result value.
REQ-014 rob_flush  out  1  one-cycle flush pulse, registered.
REQ-015 rob_ret_valid  out  1  one-cycle retire pulse, registered.
REQ-016 rob_ret_rd  out  6  retired destination register, registered.
REQ-017 rob_ret_result  out  32  retired result, registered.

Function
REQ-018 Per entry state: valid, done, error, rd[5:0], result[31:0]; head and tail pointers IDX_W bits, wrap modulo DEPTH; count 0..DEPTH.
REQ-019 rob_full = (count == DEPTH); a retire in the same cycle does not clear rob_full.
REQ-020 Allocation when rename_valid & ~rob_full & ~rob_flush: entry[tail] <= {valid=1, done=0, error=0, rd=rename_rd}; tail increments; count +1.
REQ-021 rename_valid while rob_full is ignored: no state change.
REQ-022 Writeback when wb_valid & ~rob_flush & entry[wb_robid].valid: entry sets done=1, error=wb_error, result=wb_result.
REQ-023 Writeback to an invalid entry is ignored.
REQ-024 Retire decision uses registered entry state; a writeback to the head entry retires no earlier than the following cycle.
REQ-025 Retire when entry[head] is valid, done, ~error: on that edge, rob_ret_valid <= 1, rob_ret_rd <= rd, rob_ret_result <= result; entry invalidated; head increments; count -1.
REQ-026 Maximum one retire per cycle; rob_ret_valid is 0 in every cycle without a retire; rob_ret_rd/result hold their last value.
REQ-027 Allocation and retire in the same cycle leave count unchanged.
REQ-028 Flush when entry[head] is valid, done, error: on that edge, rob_flush <= 1 for exactly one cycle; rob_ret_valid <= 0; all valid bits cleared; head, tail, count <= 0.
REQ-029 Any allocation or writeback presented on the flush edge is discarded.
REQ-030 While rob_flush is high, rename_valid and wb_valid are ignored.
REQ-031 Retire and flush are mutually exclusive in a cycle.
REQ-032 Empty (count == 0): no retire, no flush; rob_ret_valid and rob_flush remain 0.

Reset
REQ-033 rst low asynchronously clears all valid, done and error bits, head, tail, count, rob_flush, rob_ret_valid, rob_ret_rd and rob_ret_result to 0.
REQ-034 During and after reset: rob_full=0, rename_robid=0.
REQ-035 Reset asserted mid-operation discards all in-flight entries; no retire or flush pulse follows release.
REQ-036 The first allocation after reset release receives robid 0.

Verification
REQ-037 Allocate rd=5,6,7 (robid 0,1,2); wb robid1=0x22, robid0=0x11, robid2=0x33 -> three retire pulses in order rd5/0x11, rd6/0x22, rd7/0x33, one per cycle.
REQ-038 Allocate 16 with DEPTH=16 -> rob_full=1; 17th rename_valid ignored; write back and retire robid0 -> rob_full falls; next allocation gets robid 0 (wrap).
REQ-039 Allocate robid0..3; wb robid1 error=1; wb robid0 -> robid0 retires, next cycle rob_flush=1 for one cycle, robid2/3 never retire, next allocation gets robid 0.
REQ-040 Same edge: rename_valid and retire with count=5 -> count stays 5; rename_robid advances by one.
REQ-041 wb_valid to an unallocated robid 9 -> no retire, no state change.
REQ-042 Assert rst with 4 entries in flight, two done -> all outputs 0 immediately; after release no rob_ret_valid or rob_flush until a new allocation and writeback.
